// File: rtl/streamer_pkg.sv
// streamer_pkg
//   Shared types and constants for the SRAM read streamer and its FIFO.
//   - stream_state_t : sequencer state (IDLE / RUN)
//   - FIFO_DEPTH     : entries in the read-data skid FIFO
//   - FIFO_OCC_W     : width of the FIFO occupancy count (0..FIFO_DEPTH)
//   - streamer_dbg_t : debug snapshot of the sequencer (state, pending read, occupancy)
package streamer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stream_state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_OCC_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        stream_state_t         state;
        logic                  pend;
        logic [FIFO_OCC_W-1:0] occ;
    } streamer_dbg_t;

endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2
//   Two-entry first-word-fall-through FIFO used to absorb SRAM read data
//   while the downstream consumer stalls.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset (empties FIFO, zeroes storage)
//     i_push      : write i_data at the edge (ignored when full without a pop)
//     i_data      : write data
//     i_pop       : remove head at the edge (ignored when empty)
//     o_data      : head entry (0 after reset)
//     o_empty     : no entries
//     o_occ       : number of entries, 0..2
//   Push and pop in the same cycle while full is accepted; occupancy is unchanged.
module skid_fifo2
    import streamer_pkg::*;
#(
    parameter int DWIDTH = 56
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DWIDTH-1:0]     i_data,
    input  logic                  i_pop,
    output logic [DWIDTH-1:0]     o_data,
    output logic                  o_empty,
    output logic [FIFO_OCC_W-1:0] o_occ
);

    logic [DWIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [FIFO_OCC_W-1:0] r_occ;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_occ == '0);
    assign w_full    = (r_occ == FIFO_OCC_W'(FIFO_DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot the push is about to use.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_data = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + FIFO_OCC_W'(1);
                2'b01:   r_occ <= r_occ - FIFO_OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/sram_streamer.sv
// sram_streamer
//   Walks a contiguous SRAM address range after a start command and presents
//   the words, in order, on a valid/ready stream. The SRAM has a fixed
//   one-cycle registered read latency; a 2-entry FIFO absorbs it so the stream
//   runs at one word per cycle and survives arbitrary backpressure.
//   Ports:
//     clk, rst_n   : clock, synchronous active-low reset
//     start        : launch a burst (sampled only in IDLE)
//     base_addr    : first word address, latched on accepted start
//     count        : words in burst, 0..2^AWIDTH, latched on accepted start
//     busy         : burst in progress
//     done         : one-cycle pulse when a burst completes (also for count 0)
//     sram_addr_r  : read address to the SRAM
//     sram_data_i  : SRAM read data, valid the cycle after the address
//     m_valid/m_ready/m_data : output stream
//     o_dbg        : debug snapshot (state, pending read, FIFO occupancy)
//
//   Stream handshake: a word transfers at a rising edge where m_valid and
//   m_ready are both high. Once m_valid rises, m_valid and m_data hold until
//   that transfer. m_valid never depends combinationally on m_ready.
module sram_streamer
    import streamer_pkg::*;
#(
    parameter int DWIDTH = 56,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   count,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] sram_addr_r,
    input  logic [DWIDTH-1:0] sram_data_i,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output streamer_dbg_t     o_dbg
);

    stream_state_t r_state;
    stream_state_t w_state_nxt;

    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH:0]   r_count;
    logic [AWIDTH:0]   r_issued;
    logic [AWIDTH:0]   r_accepted;
    logic              r_pend;
    logic              r_done;

    logic                  w_empty;
    logic [FIFO_OCC_W-1:0] w_occ;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_zero_start;
    logic                  w_last_pop;
    logic                  w_issue;
    logic [2:0]            w_fill;

    assign w_pop = m_valid && m_ready;

    // FIFO slots already claimed: resident words plus the read in flight.
    // The pop term lets issue continue in the cycle m_ready returns.
    assign w_fill = {1'b0, w_occ} + {2'b0, r_pend};

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_zero_start = 1'b0;
        w_last_pop   = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && (count != '0)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end else if (start) begin
                    w_zero_start = 1'b1;
                end
            end
            RUN: begin
                w_issue    = (r_issued < r_count) && (w_fill < (3'd2 + {2'b0, w_pop}));
                w_last_pop = w_pop && (r_accepted == (r_count - (AWIDTH+1)'(1)));
                if (w_last_pop) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_pend     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last_pop || w_zero_start;
            r_pend <= w_issue;
            if (w_accept) begin
                r_addr     <= base_addr;
                r_count    <= count;
                r_issued   <= '0;
                r_accepted <= '0;
            end else begin
                if (w_issue) begin
                    // Wraps modulo 2^AWIDTH at the top of the array.
                    r_addr   <= r_addr + AWIDTH'(1);
                    r_issued <= r_issued + (AWIDTH+1)'(1);
                end
                if (w_pop) begin
                    r_accepted <= r_accepted + (AWIDTH+1)'(1);
                end
            end
        end
    end

    skid_fifo2 #(
        .DWIDTH (DWIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_pend),
        .i_data  (sram_data_i),
        .i_pop   (w_pop),
        .o_data  (m_data),
        .o_empty (w_empty),
        .o_occ   (w_occ)
    );

    assign m_valid     = !w_empty;
    assign busy        = (r_state == RUN);
    assign done        = r_done;
    assign sram_addr_r = r_addr;

    assign o_dbg.state = r_state;
    assign o_dbg.pend  = r_pend;
    assign o_dbg.occ   = w_occ;

endmodule

// File: tb/tb_sram_streamer.sv
// tb_sram_streamer
//   Bench for sram_streamer. A behavioural SRAM answers reads one cycle late;
//   expected words come from the SRAM contents and the burst's base/count,
//   checked in order by a monitor that also watches stall stability, done
//   pulses and timing offsets relative to the start edge.
module tb_sram_streamer;
    import streamer_pkg::*;

    localparam int DW = 56;
    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic [AW-1:0] sram_addr_r;
    logic [DW-1:0] sram_data_i;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    streamer_dbg_t dbg;

    sram_streamer #(
        .DWIDTH (DW),
        .AWIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .sram_addr_r (sram_addr_r),
        .sram_data_i (sram_data_i),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .o_dbg       (dbg)
    );

    // ---------------- clock / cycle counter ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- behavioural SRAM ----------------
    logic [DW-1:0] mem [1 << AW];
    always_ff @(posedge clk) sram_data_i <= mem[sram_addr_r];

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int hs_count, done_count, valid_count;
    int first_valid_cyc, last_hs_cyc, done_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_hold", 64'(m_valid), 64'd1);
                    check("stall_data_hold", 64'(m_data), 64'(prev_data));
                end
                if (m_valid) begin
                    valid_count++;
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                end
                if (m_valid && m_ready) begin
                    hs_count++;
                    last_hs_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 64'(m_data), 64'h0);
                        total++;
                        bad++;
                        $display("FAIL extra_word actual=0x%0h required=none", m_data);
                    end else begin
                        check("word", 64'(m_data), 64'(exp_q.pop_front()));
                    end
                end
                if (done) begin
                    done_count++;
                    done_cyc = cyc;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    end

    task automatic clear_trackers;
        hs_count        = 0;
        done_count      = 0;
        valid_count     = 0;
        first_valid_cyc = -1;
        last_hs_cyc     = -1;
        done_cyc        = -1;
    endtask

    task automatic load_expected(input logic [AW-1:0] base, input int cnt);
        logic [AW-1:0] a;
        exp_q.delete();
        for (int i = 0; i < cnt; i++) begin
            a = base + AW'(i);
            exp_q.push_back(mem[a]);
        end
    endtask

    // ---------------- burst driver + end-of-burst checks ----------------
    typedef struct {
        logic [AW-1:0] base;
        int            cnt;
        bit            rnd;
        bit            poke;
        int            lat;       // start edge -> first m_valid, -1 = don't check
        int            done_off;  // start edge -> done, -1 = don't check
    } vec_t;

    task automatic run_burst(input vec_t v);
        int start_cyc;
        int n;
        int budget;
        load_expected(v.base, v.cnt);
        clear_trackers();
        base_addr = v.base;
        count     = (AW+1)'(v.cnt);
        start     = 1'b1;
        m_ready   = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start_cyc = cyc + 1;
        step();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(v.cnt != 0));
        n      = 0;
        budget = v.cnt * 8 + 40;
        while (done_count == 0 && n < budget) begin
            if (v.poke && n == 2) begin
                start     = 1'b1;
                base_addr = v.base ^ 8'h40;
                count     = 9'd3;
            end else begin
                start = 1'b0;
            end
            m_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        start = 1'b0;
        if (done_count == 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout actual=no_done required=done within %0d cycles", budget);
        end
        m_ready = 1'b1;
        repeat (3) step();
        check("words_remaining", 64'(exp_q.size()), 64'd0);
        check("handshake_count", 64'(hs_count), 64'(v.cnt));
        check("done_pulses", 64'(done_count), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        check("valid_after_done", 64'(m_valid), 64'd0);
        if (v.cnt == 0) check("valid_never_high", 64'(valid_count), 64'd0);
        if (v.lat >= 0) check("first_valid_latency", 64'(first_valid_cyc - start_cyc), 64'(v.lat));
        if (v.done_off >= 0) check("done_offset", 64'(done_cyc - start_cyc), 64'(v.done_off));
        if (v.cnt > 0) check("done_after_last_word", 64'(done_cyc - last_hs_cyc), 64'd1);
    endtask

    // ---------------- reset in the middle of a burst ----------------
    task automatic reset_mid_burst;
        load_expected(8'h30, 10);
        clear_trackers();
        base_addr = 8'h30;
        count     = 9'd10;
        start     = 1'b1;
        m_ready   = 1'b0;
        step();
        start = 1'b0;
        repeat (4) step();
        for (int k = 0; k < 3; k++) begin
            m_ready = 1'b1;
            step();
            m_ready = 1'b0;
            repeat (3) step();
        end
        check("rst_pre_handshakes", 64'(hs_count), 64'd3);
        check("rst_pre_full", 64'(m_valid), 64'd1);
        rst_n = 1'b0;
        step();
        check("rst_mid_valid", 64'(m_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_addr", 64'(sram_addr_r), 64'd0);
        check("rst_mid_data", 64'(m_data), 64'd0);
        rst_n = 1'b1;
        exp_q.delete();
        valid_count = 0;
        m_ready     = 1'b1;
        repeat (12) step();
        check("rst_no_more_words", 64'(valid_count), 64'd0);
        check("rst_no_done", 64'(done_count), 64'd0);
        check("rst_stays_idle", 64'(busy), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs[9];

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        m_ready   = 1'b0;
        clear_trackers();
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = DW'(i * 32'h0101);
        end

        repeat (3) step();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_valid", 64'(m_valid), 64'd0);
        check("reset_addr", 64'(sram_addr_r), 64'd0);
        check("reset_data", 64'(m_data), 64'd0);
        check("reset_state", 64'(dbg.state), 64'(IDLE));
        rst_n = 1'b1;
        step();

        //          base   cnt  rnd   poke  lat done_off
        vecs[0] = '{8'h10, 8,   1'b0, 1'b0, 2,  10};
        vecs[1] = '{8'h10, 8,   1'b1, 1'b0, -1, -1};
        vecs[2] = '{8'hFE, 4,   1'b0, 1'b0, 2,  6};
        vecs[3] = '{8'h00, 0,   1'b0, 1'b0, -1, 0};
        vecs[4] = '{8'h00, 256, 1'b0, 1'b0, 2,  258};
        vecs[5] = '{8'h20, 12,  1'b1, 1'b1, -1, -1};
        vecs[6] = '{8'hF0, 1,   1'b0, 1'b0, 2,  3};
        vecs[7] = '{8'(($urandom_range(0, 255))), $urandom_range(1, 40), 1'b1, 1'b0, -1, -1};
        vecs[8] = '{8'hFA, 9,   1'b1, 1'b0, -1, -1};

        for (int i = 0; i < 9; i++) begin
            run_burst(vecs[i]);
        end

        reset_mid_burst();
        run_burst('{8'h05, 6, 1'b0, 1'b0, 2, 8});
        run_burst('{8'hF8, 16, 1'b1, 1'b0, -1, -1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_streamer.md
# sram_streamer

Read-side sequencer for the `DWIDTH`-wide dual-port weight/activation SRAM. On a `start` command it walks a contiguous address range, absorbs the SRAM's fixed one-cycle registered read latency, and presents the words in order on a valid/ready stream toward the compute array. Throughput is one word per cycle under continuous `m_ready`. Under backpressure no word is lost or duplicated.

## Interface
- `DWIDTH`, 56, SRAM word / stream data width
- `AWIDTH`, 8, SRAM address width; 2^AWIDTH words
- `clk` in 1: single clock; all state updates on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `start` in 1: launch a burst; sampled only in IDLE
- `base_addr` in AWIDTH: first word address, latched on accepted `start`
- `count` in AWIDTH+1: number of words, 0..2^AWIDTH, latched on accepted `start`
- `busy` out 1: burst in progress
- `done` out 1: one-cycle pulse at burst completion
- `sram_addr_r` out AWIDTH: read address to SRAM
- `sram_data_i` in DWIDTH: SRAM registered read data; valid the cycle after the address is presented
- `m_valid` out 1: stream word available
- `m_ready` in 1: consumer accepts
- `m_data` out DWIDTH: stream word

## Operation
**States**
- IDLE
  - `start` = 1 and `count` ≠ 0: latch `base_addr`/`count`, go to RUN.
  - `start` = 1 and `count` = 0: pulse `done` next cycle, stay IDLE.
- RUN: issue reads; go to IDLE when the final word handshakes.

**Issue rule**
- A read is issued in cycle t when all of these hold: state = RUN, issued < count, and occ + pend − pop < 2.
  - occ: FIFO occupancy. pend: read issued in t−1. pop: `m_valid` & `m_ready` in t.
- `sram_addr_r` is driven from the address register.
- On issue: the address register increments at the edge, and `pend` is set for the next cycle.
- While `pend` = 1, `sram_data_i` is pushed into the 2-entry FIFO at the edge.

**Address arithmetic**
- Address counter is AWIDTH bits and wraps mod 2^AWIDTH. Example: base 0xFE, count 4 reads 0xFE, 0xFF, 0x00, 0x01.
- Issued/accepted counters are AWIDTH+1 bits.

**Stream rules**
- `m_valid` = FIFO not empty; `m_data` = FIFO head.
- Once `m_valid` is high, `m_data` is held stable and `m_valid` stays high until the handshake.

**Completion**
- The handshake of word count−1 makes `done` = 1 and `busy` = 0 on the following cycle.
- Return to IDLE happens in that same edge.

**Boundary cases**
- `start` while busy: ignored, no effect.
- Push and pop in the same cycle with FIFO full: legal, occupancy unchanged.
- Producer must not write the active range while `busy`; this block does not check it.

**Reset** (`rst_n` = 0 at an edge, including mid-burst)
- State → IDLE; FIFO emptied; `pend` cleared; counters zeroed.
- Outputs: `busy` = 0, `done` = 0, `m_valid` = 0, `sram_addr_r` = 0, `m_data` = 0.
- Data returning from a pre-reset read is discarded.

## Timing
- `start` sampled at edge E:
  - `busy` is high from E.
  - First address is presented in E..E+1; its data is on `sram_data_i` in E+1..E+2.
  - `m_valid` is first high after edge E+2, i.e. 2-cycle start-to-data latency.
- With `m_ready` held 1, words stream back-to-back. An N-word burst has its last handshake in cycle E+N+1 and `done` in E+N+2.
- `m_ready` low for k cycles stalls at most 2 words in the FIFO. Issue resumes in the same cycle `m_ready` rises, so there are no bubbles after the stall.
- The pop term in the issue rule is the only combinational path from `m_ready`, and it goes only to issue control. There is no combinational `m_ready` → `m_valid` path.

## Structure
- Package `streamer_pkg`:
  - state enum typedef `stream_state_t` (IDLE, RUN)
  - constant `FIFO_DEPTH` = 2
- Sub-module `skid_fifo2`: 2-entry, DWIDTH-wide FIFO with push/pop/occupancy. It is instantiated once and is reusable for other SRAM readers.
- Integration: `sram_addr_r` connects directly to the SRAM `addr_r`; SRAM `data_o` connects to `sram_data_i`.

## Test plan
- Preload SRAM[i] = i·0x0101; start base 0x10, count 8, `m_ready` = 1. Required: data 0x1010..0x1717 in order on 8 consecutive cycles, first `m_valid` 2 cycles after `start`, `done` 1 cycle after the last word.
- Same burst with `m_ready` toggling pseudo-randomly. Required: same 8 words exactly once, in order, and `m_data` stable during every stall.
- Base 0xFE, count 4. Required: words from 0xFE, 0xFF, 0x00, 0x01.
- Count 0. Required: single `done` pulse, `m_valid` never high. Count 256 from base 0. Required: all 256 words, then `done`.
- Assert `rst_n` = 0 for 1 cycle after the 3rd handshake of a 10-word burst with a full FIFO. Required: `m_valid` = 0 and `busy` = 0 next cycle, no further words, `done` never pulses. A new burst afterwards streams correctly.
- Pulse `start` mid-burst with a different base/count. Required: ignored; the original burst completes unchanged.
